seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder_pkg.sv | 38 +++
 rtl/seg7_scan_decoder_if.sv | 30 +++
 rtl/seg7_scan_decoder_pattern.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// seg7_scan_decoder_pkg
// Shared definitions for the seven-segment scan decoder:
//   - SEG_TABLE   : active-low segment patterns (g..a) for hex digits 0..F
//   - state_t     : word assembly state (FILL, PRESENT)
//   - STABLE_CNT_DEF : default number of identical samples before acceptance
package seg7_scan_decoder_pkg;

  localparam int STABLE_CNT_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Entry k holds the pattern for nibble value k (leftmost element is k=15).
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
// Bundles the scanned-display input stream and the assembled-word output.
//   seg_in    : active-low segment pattern, bit0=a .. bit6=g
//   digit_sel : digit position of seg_in (0 = least significant nibble)
//   seg_valid : seg_in/digit_sel meaningful this cycle
//   out_ready : consumer accepts value this cycle
//   value     : assembled 16-bit hex word
//   out_valid : value holds a complete word
//   err       : one-cycle pulse for a stable pattern that is not a hex digit
// master = the side that drives the scan stream and consumes words,
// slave  = the decoder.
interface seg7_scan_decoder_if;
  logic [6:0]  seg_in;
  logic [1:0]  digit_sel;
  logic        seg_valid;
  logic        out_ready;
  logic [15:0] value;
  logic        out_valid;
  logic        err;

  modport master (
    output seg_in, digit_sel, seg_valid, out_ready,
    input  value, out_valid, err
  );

  modport slave (
    input  seg_in, digit_sel, seg_valid, out_ready,
    output value, out_valid, err
  );
endinterface

// File: rtl/seg7_scan_decoder_pattern.sv
// seg7_pattern_to_hex
// Purely combinational lookup of an active-low seven-segment pattern.
//   pattern : 7-bit pattern, bit0=a .. bit6=g
//   nibble  : hex value of the pattern (0 when not legal)
//   legal   : 1 when the pattern is one of the 16 table entries
module seg7_pattern_to_hex
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Debounces a multiplexed seven-segment scan stream, decodes each stable
// digit to a nibble and assembles four digits into a 16-bit word that is
// offered with a valid/ready handshake.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seg7_scan_decoder_if.slave (scan inputs, word outputs, err)
//
// state   | meaning
// FILL    | collecting digits into slots until all four are captured
// PRESENT | word on value/out_valid, waiting for out_ready; digits dropped
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  seg7_scan_decoder_if.slave  bus
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
  localparam logic [3:0] CNT_PRE = 4'(STABLE_CNT - 1);

  logic [6:0]       smp_seg_q;
  logic [1:0]       smp_sel_q;
  logic [3:0]       cnt_q;
  logic [3:0][3:0]  slots_q;
  logic [3:0]       captured_q;
  logic [15:0]      value_q;
  logic             err_q;
  state_t           state_q;
  state_t           state_d;

  logic             match;
  logic             accept;
  logic [3:0]       dec_nibble;
  logic             dec_legal;

  logic             out_valid_c;
  logic             load_value;
  logic             clear_cap;
  logic             slot_we;
  logic             slot_kill;

  seg7_pattern_to_hex u_pattern_to_hex (
    .pattern (bus.seg_in),
    .nibble  (dec_nibble),
    .legal   (dec_legal)
  );

  // The acceptance event is the sample that moves the counter onto its
  // terminal value; the counter saturates there, so a held pattern cannot
  // fire again until a different sample reloads it.
  assign match  = (bus.seg_in == smp_seg_q) && (bus.digit_sel == smp_sel_q);
  assign accept = bus.seg_valid && match && (cnt_q == CNT_PRE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      smp_seg_q <= 7'h7F;
      smp_sel_q <= 2'd0;
      cnt_q     <= 4'd0;
    end else if (bus.seg_valid) begin
      if (match) begin
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        smp_seg_q <= bus.seg_in;
        smp_sel_q <= bus.digit_sel;
        cnt_q     <= 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_c = 1'b0;
    load_value  = 1'b0;
    clear_cap   = 1'b0;
    slot_we     = 1'b0;
    slot_kill   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          slot_we   = dec_legal;
          slot_kill = !dec_legal;
        end
        if (captured_q == 4'hF) begin
          state_d    = PRESENT;
          load_value = 1'b1;
        end
      end
      PRESENT: begin
        out_valid_c = 1'b1;
        // A handshake also drops any acceptance event of the same cycle,
        // which PRESENT ignores anyway.
        if (bus.out_ready) begin
          state_d   = FILL;
          clear_cap = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slots_q    <= '0;
      captured_q <= 4'h0;
      value_q    <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      err_q <= slot_kill;
      if (clear_cap) begin
        captured_q <= 4'h0;
      end else if (slot_we) begin
        slots_q[bus.digit_sel]    <= dec_nibble;
        captured_q[bus.digit_sel] <= 1'b1;
      end else if (slot_kill) begin
        captured_q[bus.digit_sel] <= 1'b0;
      end
      if (load_value) begin
        value_q <= slots_q;
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.out_valid = out_valid_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(.STABLE_CNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [1:0] sel, input logic [6:0] seg, input int n);
    bus.digit_sel = sel;
    bus.seg_in    = seg;
    bus.seg_valid = 1'b1;
    repeat (n) tick();
    bus.seg_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; the caller judges the outcome.
  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
    ok = (bus.out_valid === 1'b1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.value !== 16'h0000) begin
      n_fail++; $display("FAIL reset_value got %h want 0000", bus.value);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", bus.err);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] e;
    hold(2'd0, 7'h30, 4);
    hold(2'd1, 7'h79, 4);
    hold(2'd2, 7'h0E, 4);
    hold(2'd3, 7'h40, 4);
    exp_q.push_back(16'h0F13);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_early got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL basic_err got %b want 0", bus.err);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency got %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL basic_value got %h want %h", bus.value, e);
    end
    handshake();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_release got %b want 0", bus.out_valid);
    end
  endtask

  // out_ready held high throughout: no effect while filling.
  task automatic test_glitch();
    bit ok;
    logic [15:0] e;
    bus.out_ready = 1'b1;
    hold(2'd0, 7'h30, 3);
    hold(2'd0, 7'h24, 4);
    hold(2'd1, 7'h79, 4);
    hold(2'd2, 7'h0E, 4);
    hold(2'd3, 7'h40, 4);
    exp_q.push_back(16'h0F12);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL glitch_timeout got out_valid %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL glitch_value got %h want %h", bus.value, e);
    end
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_release got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    logic [15:0] e;
    hold(2'd0, 7'h30, 4);
    hold(2'd0, 7'h12, 4);
    hold(2'd2, 7'h24, 4);
    hold(2'd2, 7'h7F, 4);
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_err_pulse got %b want 1", bus.err);
    end
    bus.seg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.err !== 1'b0) begin
        n_fail++; $display("FAIL illegal_err_single got %b want 0 at %0d", bus.err, i);
      end
    end
    bus.seg_valid = 1'b0;
    hold(2'd1, 7'h02, 4);
    hold(2'd3, 7'h78, 4);
    repeat (3) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_slot_cleared got %b want 0", bus.out_valid);
    end
    hold(2'd2, 7'h24, 4);
    exp_q.push_back(16'h7265);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL illegal_timeout got out_valid %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL illegal_value got %h want %h", bus.value, e);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] e;
    hold(2'd0, 7'h00, 4);
    hold(2'd1, 7'h10, 4);
    hold(2'd2, 7'h08, 4);
    hold(2'd3, 7'h03, 4);
    exp_q.push_back(16'hBA98);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_timeout got out_valid %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL bp_value got %h want %h", bus.value, e);
    end
    for (int k = 0; k < 3; k++) begin
      hold(2'(k), (k == 1) ? 7'h7F : ((k == 0) ? 7'h46 : 7'h21), 4);
      n_checks++;
      if (bus.value !== e) begin
        n_fail++; $display("FAIL bp_hold_value got %h want %h at %0d", bus.value, e, k);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_valid got %b want 1 at %0d", bus.out_valid, k);
      end
      n_checks++;
      if (bus.err !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_err got %b want 0 at %0d", bus.err, k);
      end
    end
    handshake();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got %b want 0", bus.out_valid);
    end
    hold(2'd0, 7'h06, 4);
    hold(2'd1, 7'h0E, 4);
    hold(2'd3, 7'h40, 4);
    repeat (3) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_captured_cleared got %b want 0", bus.out_valid);
    end
    hold(2'd2, 7'h19, 4);
    exp_q.push_back(16'h04FE);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_refill_timeout got out_valid %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL bp_refill_value got %h want %h", bus.value, e);
    end
    handshake();
  endtask

  task automatic test_interleave();
    logic [6:0] pat;
    logic [15:0] e;
    pat = 7'b0100101;
    hold(2'd0, 7'h79, 4);
    hold(2'd1, 7'h24, 4);
    hold(2'd2, 7'h30, 4);
    bus.digit_sel = 2'd3;
    bus.seg_in    = 7'h19;
    for (int i = 0; i < 7; i++) begin
      bus.seg_valid = pat[i];
      tick();
    end
    bus.seg_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL interleave_early got %b want 0", bus.out_valid);
    end
    bus.seg_valid = 1'b1;
    tick();
    bus.seg_valid = 1'b0;
    exp_q.push_back(16'h4321);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL interleave_latency_early got %b want 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL interleave_valid got %b want 1", bus.out_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus.value !== e) begin
      n_fail++; $display("FAIL interleave_value got %h want %h", bus.value, e);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit ok;
    hold(2'd0, 7'h40, 4);
    hold(2'd1, 7'h79, 4);
    hold(2'd2, 7'h24, 4);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.value !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_value got %h want 0000", bus.value);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid);
    end
    tick();
    reset = 1'b0;
    hold(2'd3, 7'h78, 4);
    repeat (3) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_partial_discard got %b want 0", bus.out_valid);
    end
    hold(2'd0, 7'h19, 4);
    hold(2'd1, 7'h19, 4);
    hold(2'd2, 7'h19, 4);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rstmid_refill_timeout got out_valid %b want 1", bus.out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_present_out_valid got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.value !== 16'h0000) begin
      n_fail++; $display("FAIL rst_present_value got %h want 0000", bus.value);
    end
    tick();
    reset = 1'b0;
    hold(2'd0, 7'h19, 3);
    repeat (2) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_present_no_word got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.seg_in    = 7'h7F;
    bus.digit_sel = 2'd0;
    bus.seg_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_illegal();
    test_backpressure();
    test_interleave();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
